battle_turn_scheduler: RTL and testbench

Sequences a two-player battle by owning the shared `update` path into the two `character` stat blocks. Each round it orders the players by speed and accepts one action per player over a valid/ready handshake. It converts each action into signed `hit`/`cost` values with per-character update pulses, and detects the end of the battle. It sits between the action-input logic and the two `character` instances.

---
 rtl/battle_pkg.sv | 24 ++
 rtl/battle_lfsr.sv | 10 +
 rtl/battle_turn_scheduler.sv | 154 +++++++++++++++
 tb/tb_battle_turn_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/battle_pkg.sv
// battle_pkg: action, FSM state and winner encodings plus combat constants for the turn scheduler
package battle_pkg;
    typedef enum logic [1:0] {
        ACT_ATTACK  = 2'b00,
        ACT_SPECIAL = 2'b01,
        ACT_HEAL    = 2'b10,
        ACT_PASS    = 2'b11
    } act_e;
    typedef enum logic [3:0] {
        IDLE, INIT, ORDER, WAIT_ACT, TGT_SET, TGT_PULSE, SELF_SET, SELF_PULSE, CHECK, DONE
    } state_e;
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P0   = 2'b01;
    localparam logic [1:0] WIN_P1   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;
    localparam logic [5:0] DMG_ATTACK   = 6'd8;
    localparam logic [5:0] DMG_SPECIAL  = 6'd20;
    localparam logic [5:0] HEAL_AMT     = 6'd10;
    localparam logic [2:0] COST_SPECIAL = 3'd3;
    localparam logic [2:0] COST_HEAL    = 3'd2;
    function automatic logic [1:0] health_winner(input logic [8:0] h0, input logic [8:0] h1);
        return h0 > h1 ? WIN_P0 : h0 < h1 ? WIN_P1 : WIN_DRAW;
    endfunction
endpackage

// File: rtl/battle_lfsr.sv
// battle_lfsr: free-running 4-bit LFSR (x^4+x^3+1) used for dodge rolls
module battle_lfsr (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= 4'b1001;
        else q <= {q[2:0], q[3] ^ q[2]};
endmodule

// File: rtl/battle_turn_scheduler.sv
// battle_turn_scheduler: orders two players, converts accepted actions into hit/cost update pulses, detects battle end; BATTLE_DODGE_EN adds LFSR-based dodging
module battle_turn_scheduler
    import battle_pkg::*;
#(
    parameter int MAX_ROUNDS = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] speed0,
    input  logic [2:0] speed1,
    input  logic [2:0] dodge0,
    input  logic [2:0] dodge1,
    input  logic [8:0] health0,
    input  logic [8:0] health1,
    input  logic [4:0] special0,
    input  logic [4:0] special1,
    input  logic       act_valid,
    input  logic [1:0] act_code,
    output logic       act_ready,
    output logic       active_player,
    output logic       char_rst,
    output logic       upd0,
    output logic       upd1,
    output logic [5:0] hit_out,
    output logic [2:0] cost_out,
    output logic [7:0] round_cnt,
    output logic [1:0] winner,
    output logic       done
);
    state_e     state;
    logic       pending;
    logic [5:0] l_tgt, l_self, d_tgt, d_self;
    logic [2:0] l_cost, d_cost;
    logic [4:0] sp_a;
    logic [7:0] rc_next;
    logic       miss;
    assign sp_a    = active_player ? special1 : special0;
    assign rc_next = round_cnt == 8'hFF ? round_cnt : round_cnt + 8'd1;
`ifdef BATTLE_DODGE_EN
    logic [3:0] lfsr;
    battle_lfsr u_lfsr (.clk(clk), .rst_n(rst_n), .q(lfsr));
    assign miss = lfsr < {1'b0, active_player ? dodge0 : dodge1};
`else
    logic unused_dodge;
    assign unused_dodge = ^{dodge0, dodge1};
    assign miss = 1'b0;
`endif
    // Unaffordable specials/heals degrade to pass; a miss still charges the special cost
    always_comb begin
        d_tgt  = '0;
        d_self = '0;
        d_cost = '0;
        if (act_code == ACT_ATTACK) begin
            d_tgt = miss ? 6'd0 : DMG_ATTACK;
        end else if (act_code == ACT_SPECIAL && sp_a >= {2'b0, COST_SPECIAL}) begin
            d_tgt  = miss ? 6'd0 : DMG_SPECIAL;
            d_cost = COST_SPECIAL;
        end else if (act_code == ACT_HEAL && sp_a >= {2'b0, COST_HEAL}) begin
            d_self = -HEAL_AMT;
            d_cost = COST_HEAL;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pending       <= 1'b0;
            l_tgt         <= '0;
            l_self        <= '0;
            l_cost        <= '0;
            act_ready     <= 1'b0;
            active_player <= 1'b0;
            char_rst      <= 1'b0;
            upd0          <= 1'b0;
            upd1          <= 1'b0;
            hit_out       <= '0;
            cost_out      <= '0;
            round_cnt     <= '0;
            winner        <= WIN_NONE;
            done          <= 1'b0;
        end else begin
            char_rst  <= 1'b0;
            upd0      <= 1'b0;
            upd1      <= 1'b0;
            act_ready <= 1'b0;
            hit_out   <= '0;
            cost_out  <= '0;
            case (state)
                IDLE, DONE: if (start) begin
                    state     <= INIT;
                    char_rst  <= 1'b1;
                    round_cnt <= '0;
                    winner    <= WIN_NONE;
                    done      <= 1'b0;
                end
                INIT: state <= ORDER;
                ORDER: begin
                    state         <= WAIT_ACT;
                    act_ready     <= 1'b1;
                    active_player <= speed1 > speed0;
                    pending       <= 1'b1;
                end
                WAIT_ACT: if (act_valid && act_ready) begin
                    state   <= TGT_SET;
                    l_tgt   <= d_tgt;
                    l_self  <= d_self;
                    l_cost  <= d_cost;
                    hit_out <= d_tgt;
                end else begin
                    act_ready <= 1'b1;
                end
                TGT_SET: begin
                    state   <= TGT_PULSE;
                    hit_out <= l_tgt;
                    upd0    <= l_tgt != '0 && active_player;
                    upd1    <= l_tgt != '0 && !active_player;
                end
                TGT_PULSE: begin
                    state    <= SELF_SET;
                    hit_out  <= l_self;
                    cost_out <= l_cost;
                end
                SELF_SET: begin
                    state    <= SELF_PULSE;
                    hit_out  <= l_self;
                    cost_out <= l_cost;
                    upd0     <= (l_self != '0 || l_cost != '0) && !active_player;
                    upd1     <= (l_self != '0 || l_cost != '0) && active_player;
                end
                SELF_PULSE: state <= CHECK;
                CHECK: if (health0 == '0 || health1 == '0) begin
                    state  <= DONE;
                    done   <= 1'b1;
                    winner <= health0 == '0 && health1 == '0 ? WIN_DRAW : health0 == '0 ? WIN_P1 : WIN_P0;
                end else if (pending) begin
                    state         <= WAIT_ACT;
                    act_ready     <= 1'b1;
                    pending       <= 1'b0;
                    active_player <= !active_player;
                end else begin
                    round_cnt <= rc_next;
                    if (rc_next == 8'(MAX_ROUNDS)) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        winner <= health_winner(health0, health1);
                    end else begin
                        state <= ORDER;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_battle_turn_scheduler.sv
// tb_battle_turn_scheduler: table-driven action vectors plus hand sequences for end, round cap, abort and dodge
module tb_battle_turn_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] speed0 = '0, speed1 = '0, dodge0 = '0, dodge1 = '0;
    logic [8:0] health0 = 9'd100, health1 = 9'd100;
    logic [4:0] special0 = '0, special1 = '0;
    logic       act_valid = 1'b0;
    logic [1:0] act_code = '0;
    logic       act_ready, active_player, char_rst, upd0, upd1, done;
    logic [5:0] hit_out;
    logic [2:0] cost_out;
    logic [7:0] round_cnt;
    logic [1:0] winner;
    int n_chk = 0;
    int n_fail = 0;

    battle_turn_scheduler #(.MAX_ROUNDS(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .speed0(speed0), .speed1(speed1), .dodge0(dodge0), .dodge1(dodge1),
        .health0(health0), .health1(health1), .special0(special0), .special1(special1),
        .act_valid(act_valid), .act_code(act_code), .act_ready(act_ready),
        .active_player(active_player), .char_rst(char_rst), .upd0(upd0), .upd1(upd1),
        .hit_out(hit_out), .cost_out(cost_out), .round_cnt(round_cnt), .winner(winner), .done(done)
    );

    always #5 clk = ~clk;

`ifdef BATTLE_DODGE_EN
    logic [3:0] m_lfsr;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_lfsr <= 4'b1001;
        else m_lfsr <= {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
`endif

    typedef struct packed {
        logic [2:0] s0, s1;
        logic [4:0] sp;
        logic [1:0] code;
        logic       ap;
        logic [5:0] th, sh;
        logic [2:0] c;
        logic       tu, su;
    } vec_t;
    vec_t v[8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        start = 1'b0;
        act_valid = 1'b0;
        repeat (2) tick;
        chk("reset_outputs", {act_ready, active_player, char_rst, upd0, upd1, hit_out, cost_out, round_cnt, winner, done}, 0);
        rst_n = 1'b1;
    endtask

    task automatic begin_battle;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("char_rst_cycle1", char_rst, 1);
        tick;
        chk("ready_low_cycle2", act_ready, 0);
        tick;
        chk("ready_cycle3", act_ready, 1);
    endtask

    task automatic run_cap(input logic [8:0] h0, input logic [8:0] h1, input logic [1:0] w);
        int cnt;
        do_reset;
        speed0 = 3'd3; speed1 = 3'd3; special0 = '0; special1 = '0;
        health0 = h0; health1 = h1;
        begin_battle;
        for (int k = 0; k < 4; k++) begin
            act_code = 2'b11;
            act_valid = 1'b1;
            tick;
            act_valid = 1'b0;
            if (k < 3) begin
                cnt = 1;
                while (!act_ready && cnt < 20) begin
                    tick;
                    cnt++;
                end
                chk("cap_latency", cnt, k == 1 ? 7 : 6);
                chk("cap_round_cnt", round_cnt, k >= 1 ? 1 : 0);
            end
        end
        repeat (5) tick;
        chk("cap_done", done, 1);
        chk("cap_rounds", round_cnt, 2);
        chk("cap_winner", winner, w);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        //        s0    s1    sp     code   ap    th      sh      c     tu    su
        v[0] = {3'd4, 3'd6, 5'd10, 2'b00, 1'b1, 6'd8,  6'd0,  3'd0, 1'b1, 1'b0};
        v[1] = {3'd6, 3'd4, 5'd2,  2'b01, 1'b0, 6'd0,  6'd0,  3'd0, 1'b0, 1'b0};
        v[2] = {3'd5, 3'd5, 5'd10, 2'b10, 1'b0, 6'd0,  6'h36, 3'd2, 1'b0, 1'b1};
        v[3] = {3'd0, 3'd7, 5'd3,  2'b01, 1'b1, 6'd20, 6'd0,  3'd3, 1'b1, 1'b1};
        v[4] = {3'd7, 3'd0, 5'd1,  2'b10, 1'b0, 6'd0,  6'd0,  3'd0, 1'b0, 1'b0};
        v[5] = {3'd2, 3'd2, 5'd0,  2'b11, 1'b0, 6'd0,  6'd0,  3'd0, 1'b0, 1'b0};
        v[6] = {3'd3, 3'd1, 5'd5,  2'b00, 1'b0, 6'd8,  6'd0,  3'd0, 1'b1, 1'b0};
        v[7] = {3'd1, 3'd2, 5'd2,  2'b10, 1'b1, 6'd0,  6'h36, 3'd2, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            do_reset;
            speed0 = v[i].s0; speed1 = v[i].s1;
            special0 = v[i].sp; special1 = v[i].sp;
            health0 = 9'd100; health1 = 9'd100;
            dodge0 = '0; dodge1 = '0;
            begin_battle;
            chk("first_mover", active_player, v[i].ap);
            act_code = v[i].code;
            act_valid = 1'b1;
            tick;
            act_valid = 1'b0;
            chk("tgt_set_hit", hit_out, v[i].th);
            chk("tgt_set_cost", cost_out, 0);
            chk("tgt_set_upd", {upd1, upd0}, 0);
            tick;
            chk("tgt_pulse_upd", v[i].ap ? upd0 : upd1, v[i].tu);
            chk("tgt_pulse_actor_upd", v[i].ap ? upd1 : upd0, 0);
            chk("tgt_pulse_hit", hit_out, v[i].th);
            tick;
            chk("self_set_hit", hit_out, v[i].sh);
            chk("self_set_cost", cost_out, v[i].c);
            chk("self_set_upd", {upd1, upd0}, 0);
            tick;
            chk("self_pulse_upd", v[i].ap ? upd1 : upd0, v[i].su);
            chk("self_pulse_tgt_upd", v[i].ap ? upd0 : upd1, 0);
            chk("self_pulse_cost", cost_out, v[i].c);
            tick;
            chk("check_idle_outputs", {upd1, upd0, hit_out, cost_out, act_ready}, 0);
            tick;
            chk("second_ready", act_ready, 1);
            chk("second_mover", active_player, !v[i].ap);
        end

        // Knockout, DONE hold, ignored start mid-battle, restart from DONE
        do_reset;
        speed0 = 3'd4; speed1 = 3'd6; special0 = 5'd10; special1 = 5'd10;
        health0 = 9'd100; health1 = 9'd100;
        begin_battle;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("start_ignored_rst", char_rst, 0);
        chk("start_ignored_ready", act_ready, 1);
        act_code = 2'b00;
        act_valid = 1'b1;
        tick;
        act_valid = 1'b0;
        health1 = 9'd0;
        repeat (4) tick;
        chk("ko_not_done_in_check", done, 0);
        tick;
        chk("ko_winner", winner, 2'b01);
        chk("ko_done", done, 1);
        chk("ko_ready", act_ready, 0);
        act_valid = 1'b1;
        repeat (3) begin
            tick;
            chk("done_hold_ready", act_ready, 0);
            chk("done_hold_upd", {upd1, upd0}, 0);
            chk("done_hold_winner", winner, 2'b01);
        end
        act_valid = 1'b0;
        health1 = 9'd100;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("restart_char_rst", char_rst, 1);
        chk("restart_winner", winner, 0);
        chk("restart_done", done, 0);

        run_cap(9'd50, 9'd50, 2'b11);
        run_cap(9'd60, 9'd40, 2'b01);
        run_cap(9'd10, 9'd90, 2'b10);

        // Asynchronous abort while a strobe is high
        do_reset;
        speed0 = 3'd4; speed1 = 3'd6; special0 = 5'd10; special1 = 5'd10;
        health0 = 9'd100; health1 = 9'd100;
        begin_battle;
        act_code = 2'b00;
        act_valid = 1'b1;
        tick;
        act_valid = 1'b0;
        tick;
        chk("abort_pre_upd0", upd0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_upd_async", {upd1, upd0, hit_out, act_ready}, 0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("abort_idle_ready", act_ready, 0);

`ifdef BATTLE_DODGE_EN
        do_reset;
        speed0 = 3'd6; speed1 = 3'd4; special0 = 5'd10; special1 = 5'd10;
        dodge0 = 3'd0; dodge1 = 3'd7;
        begin_battle;
        begin
            int waited = 0;
            while (m_lfsr != 4'd3 && waited < 40) begin
                tick;
                waited++;
            end
            chk("dodge_lfsr_found", m_lfsr, 4'd3);
        end
        act_code = 2'b01;
        act_valid = 1'b1;
        tick;
        act_valid = 1'b0;
        chk("dodge_tgt_hit", hit_out, 0);
        tick;
        chk("dodge_no_upd1", upd1, 0);
        tick;
        chk("dodge_cost", cost_out, 3);
        tick;
        chk("dodge_actor_upd0", upd0, 1);
        dodge1 = 3'd0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
